// File: rtl/z80_blkxfer_pkg.sv
// Shared encodings for the Z80 block-instruction sequencer: register-file
// command codes, flag bit positions, FSM states and opcode decode helpers.
package z80_blkxfer_pkg;

  localparam logic [2:0] CMD_NOPE = 3'd0;
  localparam logic [2:0] CMD_INC  = 3'd1;
  localparam logic [2:0] CMD_DEC  = 3'd2;

  localparam int SIGN   = 7;
  localparam int ZERO   = 6;
  localparam int HALF   = 4;
  localparam int PARITY = 2;
  localparam int NEG    = 1;
  localparam int CARRY  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_UPD,
    ST_DONE
  } blk_state_t;

  typedef struct packed {
    logic is_cp;
    logic is_dec;
    logic is_rep;
  } blk_op_t;

  // Legal forms are 101x_x00x: A0/A1/A8/A9/B0/B1/B8/B9.
  function automatic logic is_legal_op(input logic [7:0] op);
    return (op[7:5] == 3'b101) && (op[2:1] == 2'b00);
  endfunction

  function automatic blk_op_t decode_op(input logic [7:0] op);
    blk_op_t d;
    d.is_cp  = op[0];
    d.is_dec = op[3];
    d.is_rep = op[4];
    return d;
  endfunction

endpackage

// File: rtl/z80_blk_flags.sv
// Combinational flag image for one LDx/CPx iteration, plus the CP match
// indication (A equals the byte just read).
module z80_blk_flags
  import z80_blkxfer_pkg::*;
(
  input  logic [7:0]  a,
  input  logic [7:0]  f,
  input  logic [7:0]  data,
  input  logic [15:0] bc,
  input  logic        is_cp,
  output logic [7:0]  flag,
  output logic        match
);

  // C and the undocumented bits 5/3 always survive; LD also keeps S and Z.
  localparam logic [7:0] KEEP_ALL = (8'd1 << CARRY) | 8'h28;
  localparam logic [7:0] KEEP_LD  = KEEP_ALL | (8'd1 << SIGN) | (8'd1 << ZERO);

  logic [7:0] r;

  always_comb begin
    r     = a - data;
    match = (r == 8'h00);
    flag  = f & (is_cp ? KEEP_ALL : KEEP_LD);
    flag[PARITY] = (bc != 16'h0001);
    if (is_cp) begin
      flag[SIGN] = r[7];
      flag[ZERO] = (r == 8'h00);
      flag[HALF] = (a[3:0] < data[3:0]);
      flag[NEG]  = 1'b1;
    end
  end

endmodule

// File: rtl/z80_blkxfer.sv
// Sequencer for LDI/LDD/LDIR/LDDR/CPI/CPD/CPIR/CPDR: performs the memory
// traffic per iteration and drives the register-file command and flag ports.
module z80_blkxfer
  import z80_blkxfer_pkg::*;
(
  input  logic        pin_clk,
  input  logic        pin_rst,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [7:0]  a,
  input  logic [7:0]  f,
  input  logic [15:0] bc,
  input  logic [15:0] de,
  input  logic [15:0] hl,
  input  logic        irq_pending,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [2:0]  cmd,
  output logic        flg_w,
  output logic [7:0]  flag,
  output logic        busy,
  output logic        done,
  output logic        again
);

  blk_state_t state_q, state_d;
  blk_op_t    op_q;
  logic [7:0] data_q, data_d;
  logic       match_q, last_q;
  logic [7:0] flag_c;
  logic       match_c;
  logic       stop_c, again_c;

  logic       mem_req_q, mem_we_q, flg_w_q, busy_q, done_q, again_q;
  logic [2:0] cmd_q;
  logic [7:0] flag_q;

  // Flags are evaluated on the cycle that enters UPD, so the byte being
  // latched is forwarded and bc is still the pre-decrement value.
  z80_blk_flags u_flags (
    .a     (a),
    .f     (f),
    .data  (data_d),
    .bc    (bc),
    .is_cp (op_q.is_cp),
    .flag  (flag_c),
    .match (match_c)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    again_c   = 1'b0;
    stop_c    = !op_q.is_rep || last_q || (op_q.is_cp && match_q);
    if (state_q == ST_RD && mem_ack) begin
      data_d = mem_rdata;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = is_legal_op(opcode) ? ST_RD : ST_DONE;
        end
      end
      ST_RD: begin
        mem_addr = hl;
        if (mem_ack) begin
          state_d = op_q.is_cp ? ST_UPD : ST_WR;
        end
      end
      ST_WR: begin
        mem_addr  = de;
        mem_wdata = data_q;
        if (mem_ack) begin
          state_d = ST_UPD;
        end
      end
      ST_UPD: begin
        again_c = !stop_c && irq_pending;
        state_d = (!stop_c && !irq_pending) ? ST_RD : ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      match_q   <= 1'b0;
      last_q    <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      cmd_q     <= CMD_NOPE;
      flg_w_q   <= 1'b0;
      flag_q    <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      again_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        op_q <= decode_op(opcode);
      end
      if (state_d == ST_UPD) begin
        flag_q  <= flag_c;
        match_q <= match_c;
        last_q  <= (bc == 16'h0001);
      end
      // Outputs are registered from the next state so they line up with it.
      mem_req_q <= (state_d == ST_RD) || (state_d == ST_WR);
      mem_we_q  <= (state_d == ST_WR);
      cmd_q     <= (state_d == ST_UPD) ? (op_q.is_dec ? CMD_DEC : CMD_INC) : CMD_NOPE;
      flg_w_q   <= (state_d == ST_UPD);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      again_q   <= again_c;
    end
  end

  always_ff @(posedge pin_clk) begin
    data_q <= data_d;
  end

  assign mem_req = mem_req_q;
  assign mem_we  = mem_we_q;
  assign cmd     = cmd_q;
  assign flg_w   = flg_w_q;
  assign flag    = flag_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign again   = again_q;

endmodule

// File: tb/tb_z80_blkxfer.sv
// Scoreboard bench for z80_blkxfer: directed instructions push expected
// writes/commands/flags/done events; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_z80_blkxfer;
  import z80_blkxfer_pkg::*;

  logic        pin_clk = 1'b0;
  logic        pin_rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic        irq_pending = 1'b0;
  logic [7:0]  rf_a = 8'h00, rf_f = 8'h00;
  logic [15:0] rf_bc = 16'h0, rf_de = 16'h0, rf_hl = 16'h0;
  logic        rf_ld = 1'b1;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [2:0]  cmd;
  logic        flg_w, busy, done, again;
  logic [7:0]  flag;

  logic [7:0]  mem [0:65535];
  int          ack_delay = 0;
  int          age = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          ld_seq = 0, ld_seen = 0, idle_seq = 0, idle_seen = 0;
  int          end_seq = 0, end_seen = 0, tmo_seq = 0, tmo_seen = 0;
  logic        noop_chk = 1'b0;
  logic [7:0]  ld_a = 8'h00, ld_f = 8'h00;
  logic [15:0] ld_bc = 16'h0, ld_de = 16'h0, ld_hl = 16'h0;
  logic        ld_ld = 1'b1;
  int          mon_rel;
  logic [31:0] mon_act;
  logic [31:0] exp_wr[$], exp_cmd[$], exp_flag[$], exp_done[$];

  z80_blkxfer dut (
    .pin_clk     (pin_clk),
    .pin_rst     (pin_rst),
    .start       (start),
    .opcode      (opcode),
    .a           (rf_a),
    .f           (rf_f),
    .bc          (rf_bc),
    .de          (rf_de),
    .hl          (rf_hl),
    .irq_pending (irq_pending),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .cmd         (cmd),
    .flg_w       (flg_w),
    .flag        (flag),
    .busy        (busy),
    .done        (done),
    .again       (again)
  );

  always #5 pin_clk = ~pin_clk;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && (age >= ack_delay);

  always @(posedge pin_clk) begin
    cyc <= cyc + 1;
    age <= (mem_req && !mem_ack) ? age + 1 : 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (rel cycle %0d)", name, act, exp, cyc - start_cyc);
    end
  endtask

  // Monitor and register-file model: compare first, then apply this cycle's update.
  always begin
    @(negedge pin_clk);
    mon_rel = cyc - start_cyc;
    if (mem_req && mem_we && mem_ack) begin
      mon_act = {mem_addr, 8'h00, mem_wdata};
      if (exp_wr.size() == 0) chk("mem_write_unexpected", mon_act, 32'hFFFF_FFFF);
      else chk("mem_write", mon_act, exp_wr.pop_front());
    end
    if (cmd != CMD_NOPE) begin
      mon_act = {16'(mon_rel), 13'd0, cmd};
      if (exp_cmd.size() == 0) chk("cmd_unexpected", mon_act, 32'hFFFF_FFFF);
      else chk("cmd_cycle_value", mon_act, exp_cmd.pop_front());
    end
    if (flg_w) begin
      mon_act = {24'd0, flag};
      if (exp_flag.size() == 0) chk("flag_unexpected", mon_act, 32'hFFFF_FFFF);
      else chk("flag_value", mon_act, exp_flag.pop_front());
    end
    if (done) begin
      done_cnt++;
      mon_act = {16'(mon_rel), 15'd0, again};
      if (exp_done.size() == 0) chk("done_unexpected", mon_act, 32'hFFFF_FFFF);
      else chk("done_cycle_again", mon_act, exp_done.pop_front());
    end
    if (noop_chk) begin
      chk("noop_mem_req", {31'd0, mem_req}, 32'd0);
      chk("noop_flg_w", {31'd0, flg_w}, 32'd0);
    end
    if (idle_seq != idle_seen) begin
      idle_seen = idle_seq;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      chk("rst_cmd", {29'd0, cmd}, {29'd0, CMD_NOPE});
      chk("rst_flg_w", {31'd0, flg_w}, 32'd0);
      chk("rst_flag", {24'd0, flag}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_again", {31'd0, again}, 32'd0);
    end
    if (end_seq != end_seen) begin
      end_seen = end_seq;
      chk("left_writes", 32'(exp_wr.size()), 32'd0);
      chk("left_cmds", 32'(exp_cmd.size()), 32'd0);
      chk("left_flags", 32'(exp_flag.size()), 32'd0);
      chk("left_dones", 32'(exp_done.size()), 32'd0);
      exp_wr.delete(); exp_cmd.delete(); exp_flag.delete(); exp_done.delete();
    end
    if (tmo_seq != tmo_seen) begin
      tmo_seen = tmo_seq;
      chk("wait_timeout", 32'd1, 32'd0);
    end
    if (ld_seq != ld_seen) begin
      ld_seen = ld_seq;
      rf_a = ld_a; rf_f = ld_f; rf_bc = ld_bc; rf_de = ld_de; rf_hl = ld_hl; rf_ld = ld_ld;
    end else begin
      if (cmd == CMD_INC) begin
        rf_hl = rf_hl + 16'd1;
        if (rf_ld) rf_de = rf_de + 16'd1;
        rf_bc = rf_bc - 16'd1;
      end else if (cmd == CMD_DEC) begin
        rf_hl = rf_hl - 16'd1;
        if (rf_ld) rf_de = rf_de - 16'd1;
        rf_bc = rf_bc - 16'd1;
      end
      if (flg_w) rf_f = flag;
    end
  end

  task automatic load(input logic [7:0] ta, input logic [7:0] tf, input logic [15:0] tbc,
                      input logic [15:0] tde, input logic [15:0] thl, input logic tld);
    ld_a = ta; ld_f = tf; ld_bc = tbc; ld_de = tde; ld_hl = thl; ld_ld = tld;
    ld_seq++;
    repeat (2) @(negedge pin_clk);
  endtask

  task automatic issue(input logic [7:0] op);
    opcode = op;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge pin_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    int k;
    n0 = done_cnt;
    k = 0;
    while (done_cnt == n0 && k < budget) begin
      @(negedge pin_clk);
      k++;
    end
    if (done_cnt == n0) tmo_seq++;
  endtask

  task automatic finish_test();
    repeat (2) @(negedge pin_clk);
    end_seq++;
    repeat (2) @(negedge pin_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    pin_rst = 1'b1;
    repeat (3) @(negedge pin_clk);
    idle_seq++;
    repeat (2) @(negedge pin_clk);
    pin_rst = 1'b0;
    @(negedge pin_clk);

    // LDI: one byte, S/Z/C kept from F with bit 3 clear, PV=1.
    mem[16'h4000] = 8'h5A;
    load(8'h00, 8'hF7, 16'd2, 16'h8000, 16'h4000, 1'b1);
    exp_wr.push_back({16'h8000, 8'h00, 8'h5A});
    exp_cmd.push_back({16'd3, 13'd0, CMD_INC});
    exp_flag.push_back(32'h0000_00E5);
    exp_done.push_back({16'd4, 16'd0});
    issue(8'hA0);
    wait_done(50);
    finish_test();

    // LDIR bc=3, with a stray start while busy that must be ignored.
    mem[16'h4010] = 8'h11; mem[16'h4011] = 8'h22; mem[16'h4012] = 8'h33;
    load(8'h00, 8'h00, 16'd3, 16'h9000, 16'h4010, 1'b1);
    exp_wr.push_back({16'h9000, 8'h00, 8'h11});
    exp_wr.push_back({16'h9001, 8'h00, 8'h22});
    exp_wr.push_back({16'h9002, 8'h00, 8'h33});
    exp_cmd.push_back({16'd3, 13'd0, CMD_INC});
    exp_cmd.push_back({16'd6, 13'd0, CMD_INC});
    exp_cmd.push_back({16'd9, 13'd0, CMD_INC});
    exp_flag.push_back(32'h04); exp_flag.push_back(32'h04); exp_flag.push_back(32'h00);
    exp_done.push_back({16'd10, 16'd0});
    issue(8'hB0);
    while (cyc - start_cyc < 5) @(negedge pin_clk);
    opcode = 8'hA1; start = 1'b1;
    @(negedge pin_clk);
    start = 1'b0;
    wait_done(60);
    finish_test();

    // CPIR stops on the match at the 2nd byte.
    mem[16'h5000] = 8'h10; mem[16'h5001] = 8'h42; mem[16'h5002] = 8'h99;
    load(8'h42, 8'h00, 16'd5, 16'h0000, 16'h5000, 1'b0);
    exp_cmd.push_back({16'd2, 13'd0, CMD_INC});
    exp_cmd.push_back({16'd4, 13'd0, CMD_INC});
    exp_flag.push_back(32'h06); exp_flag.push_back(32'h46);
    exp_done.push_back({16'd5, 16'd0});
    issue(8'hB1);
    wait_done(60);
    finish_test();

    // CPD with two wait states: half-borrow, C/5/3 kept, PV=0 at bc=1.
    ack_delay = 2;
    mem[16'h6000] = 8'h01;
    load(8'h10, 8'h29, 16'd1, 16'h0000, 16'h6000, 1'b0);
    exp_cmd.push_back({16'd4, 13'd0, CMD_DEC});
    exp_flag.push_back(32'h3B);
    exp_done.push_back({16'd5, 16'd0});
    issue(8'hA9);
    wait_done(60);
    ack_delay = 0;
    finish_test();

    // LDDR bc=10 interrupted during the 2nd iteration.
    mem[16'h7009] = 8'hC3; mem[16'h7008] = 8'h3C;
    load(8'h00, 8'hFF, 16'd10, 16'hA009, 16'h7009, 1'b1);
    exp_wr.push_back({16'hA009, 8'h00, 8'hC3});
    exp_wr.push_back({16'hA008, 8'h00, 8'h3C});
    exp_cmd.push_back({16'd3, 13'd0, CMD_DEC});
    exp_cmd.push_back({16'd6, 13'd0, CMD_DEC});
    exp_flag.push_back(32'hED); exp_flag.push_back(32'hED);
    exp_done.push_back({16'd7, 16'd1});
    issue(8'hB8);
    while (cyc - start_cyc < 4) @(negedge pin_clk);
    irq_pending = 1'b1;
    wait_done(60);
    irq_pending = 1'b0;
    finish_test();

    // LDIR with bc=0 counts as 65536: PV=1, continues, so an irq yields again=1.
    load(8'h00, 8'h00, 16'd0, 16'h8100, 16'h4000, 1'b1);
    irq_pending = 1'b1;
    exp_wr.push_back({16'h8100, 8'h00, 8'h5A});
    exp_cmd.push_back({16'd3, 13'd0, CMD_INC});
    exp_flag.push_back(32'h04);
    exp_done.push_back({16'd4, 16'd1});
    issue(8'hB0);
    wait_done(50);
    irq_pending = 1'b0;
    finish_test();

    // Reset while WR waits for an ack that never comes.
    ack_delay = 1;
    load(8'h00, 8'h00, 16'd2, 16'h8200, 16'h4000, 1'b1);
    issue(8'hA0);
    begin
      int k;
      k = 0;
      while (!mem_we && k < 10) begin
        @(negedge pin_clk);
        k++;
      end
      if (!mem_we) tmo_seq++;
    end
    pin_rst = 1'b1;
    @(negedge pin_clk);
    idle_seq++;
    @(negedge pin_clk);
    pin_rst = 1'b0;
    ack_delay = 0;
    finish_test();

    // Illegal opcode: done pulse only.
    noop_chk = 1'b1;
    exp_done.push_back({16'd1, 16'd0});
    issue(8'hA2);
    wait_done(10);
    repeat (2) @(negedge pin_clk);
    noop_chk = 1'b0;
    finish_test();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
